cla16_seq_ctrl: RTL and testbench
=================================

# cla16_seq_ctrl

Multi-cycle sequencer that time-shares one 16-bit ripple-of-CLA4 adder (`cla16ripple`) to add wide operands, 16 bits per clock. It latches two `16*WORDS`-bit operands on a start pulse and walks them LSB-chunk first. Each chunk's carry is registered and fed back as the next chunk's carry-in. It then presents the full sum and carry-out with a one-cycle done pulse. It sits between the datapath's operand registers and any consumer that needs a wide add without paying for `WORDS` adder instances.

## Interface
- `WORDS`, default 4: number of 16-bit chunks; operand width = `16*WORDS`, legal range 2..16.
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; sampled only when not busy.
- `a`, input, `16*WORDS`: operand A; sampled with `start`.
- `b`, input, `16*WORDS`: operand B; sampled with `start`.
- `carryInput`, input, 1: carry into chunk 0; sampled with `start`.
- `sub`, input, 1: present only with `CLA16_SEQ_SUB_EN`; sampled with `start`.
- `busy`, output, 1: high while chunks are being processed.
- `done`, output, 1: one-cycle pulse when `sum`/`carryOutput` become valid.
- `sum`, output, `16*WORDS`: result register.
- `carryOutput`, output, 1: carry out of the top chunk.

## Operation
- Single instance of `cla16ripple`. Its inputs are driven from the operand registers sliced by chunk index `idx`; carry-in comes from the carry register.
- States:
  - **IDLE**: `busy`=0.
  - **RUN**: `busy`=1.
  - **DONE**: `busy`=0, `done`=1.
- **IDLE/DONE + start=1**:
  - Latch `a`, `b`, `carryInput` (and `sub`).
  - Set `idx`=0, carry reg = `carryInput`, state → RUN.
  - `sum` is not cleared; it holds the previous result until overwritten chunk by chunk.
- **RUN**, each cycle:
  - Write `sum[16*idx+15:16*idx]` from the adder.
  - Carry reg ← adder `carryOutput`.
  - If `idx`==`WORDS-1`: state → DONE and `carryOutput` ← adder carry. Otherwise `idx`++.
- **DONE, start=0**: → IDLE. `sum`/`carryOutput` hold until the next accepted start.
- `start` while RUN is ignored; it is not queued. Operand input changes while RUN have no effect.
- Arithmetic: `{carryOutput,sum}` = `a + b + carryInput`, modulo `2^(16*WORDS+1)`.
- `carryOutput` updates only on the DONE transition, never mid-operation. Intermediate `sum` chunks are visible but not valid until `done`.
- Reset, asynchronous, at any time including mid-RUN:
  - state=IDLE, `idx`=0, carry reg=0.
  - `busy`=0, `done`=0, `sum`=0, `carryOutput`=0, operand regs=0.
  - No partial result survives.

## Timing
- Start accepted at edge E0. Chunk k is written at edge E(k+1). DONE is entered at edge E`WORDS`.
- `done` is high for exactly the cycle after E`WORDS`. Latency from accepted start to `done` = `WORDS` cycles.
- `busy` rises the cycle after E0 and falls together with `done` rising.
- Back-to-back operation: `start` high during the DONE cycle is accepted. Throughput = one operation per `WORDS+1` cycles.
- Critical path: one `cla16ripple` plus the chunk mux; no other combinational path crosses chunks.

## Configuration
- `CLA16_SEQ_SUB_EN` defined:
  - `sub` port exists.
  - When `sub`=1 at start, B is complemented per chunk and the initial carry is forced to 1; `carryInput` is ignored.
  - Result is `a - b`; `carryOutput`=1 means no borrow (`a >= b` unsigned).
  - `sub`=0 behaves exactly as the add-only build.
- Not defined: no `sub` port, add-only; complement logic is absent.

## Test plan
- WORDS=4, `a`=0x0000_0000_0000_FFFF, `b`=0x1, `carryInput`=0 → `done` 4 cycles after start edge, `sum`=0x0000_0000_0001_0000, `carryOutput`=0.
- `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0x1 → `sum`=0, `carryOutput`=1; carry ripples through all 4 chunks.
- `a`=`b`=0x8000_0000_0000_0000, `carryInput`=1 → `sum`=0x1, `carryOutput`=1.
- Start at cycle 0, then pulse `start` with new operands while `busy` → ignored; the first result completes unchanged. A start during the DONE cycle is accepted, and the second result arrives 5 cycles after the first `done`.
- Assert `rst` when `idx`=2 → `busy`, `done`, `sum`, `carryOutput` = 0 immediately. After release, a fresh start of 3+4 yields `sum`=7.
- `CLA16_SEQ_SUB_EN`, `sub`=1:
  - `a`=5, `b`=7 → `sum`=0xFFFF_FFFF_FFFF_FFFE, `carryOutput`=0.
  - `a`=7, `b`=5 → `sum`=2, `carryOutput`=1.

Source files
------------

// File: rtl/cla16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla16_seq_ctrl (with cla4, cla16ripple)
// Purpose  : Wide adder sequencer, one 16-bit chunk per clock through a single
//            ripple-of-CLA4 adder. Optional subtract mode: CLA16_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carryInput,
    output logic [3:0] sum,
    output logic       carryOutput
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = carryInput;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign sum         = w_p ^ w_c[3:0];
    assign carryOutput = w_c[4];
endmodule

module cla16ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryInput,
    output logic [15:0] sum,
    output logic        carryOutput
);
    logic [4:0] w_c;

    assign w_c[0] = carryInput;

    for (genvar i = 0; i < 4; i++) begin : g_cla4
        cla4 u_cla4 (
            .a           (a[4*i +: 4]),
            .b           (b[4*i +: 4]),
            .carryInput  (w_c[i]),
            .sum         (sum[4*i +: 4]),
            .carryOutput (w_c[i+1])
        );
    end

    assign carryOutput = w_c[4];
endmodule

module cla16_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                carryInput,
`ifdef CLA16_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                carryOutput
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [15:0]     a_q   [WORDS];
    logic [15:0]     a_d   [WORDS];
    logic [15:0]     b_q   [WORDS];
    logic [15:0]     b_d   [WORDS];
    logic [15:0]     sum_q [WORDS];
    logic [15:0]     sum_d [WORDS];

    logic [15:0]     w_a_words [WORDS];
    logic [15:0]     w_b_words [WORDS];
    logic [15:0]     w_add_a;
    logic [15:0]     w_add_b;
    logic [15:0]     w_add_sum;
    logic            w_add_cout;
    logic            w_init_carry;

    for (genvar i = 0; i < WORDS; i++) begin : g_pack
        assign w_a_words[i]   = a[16*i +: 16];
        assign w_b_words[i]   = b[16*i +: 16];
        assign sum[16*i +: 16] = sum_q[i];
    end

    assign w_add_a = a_q[idx_q];

`ifdef CLA16_SEQ_SUB_EN
    logic sub_q, sub_d;

    // Two's-complement subtract: invert B chunk by chunk, seed carry with 1.
    assign w_add_b      = b_q[idx_q] ^ {16{sub_q}};
    assign w_init_carry = sub ? 1'b1 : carryInput;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    always_comb begin
        sub_d = sub_q;
        if ((state_q != ST_RUN) && start) begin
            sub_d = sub;
        end
    end
`else
    assign w_add_b      = b_q[idx_q];
    assign w_init_carry = carryInput;
`endif

    cla16ripple u_adder (
        .a           (w_add_a),
        .b           (w_add_b),
        .carryInput  (carry_q),
        .sum         (w_add_sum),
        .carryOutput (w_add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Previous sum is left in place; it is overwritten chunk by chunk.
                if (start) begin
                    a_d     = w_a_words;
                    b_d     = w_b_words;
                    carry_d = w_init_carry;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[idx_q] = w_add_sum;
                carry_d      = w_add_cout;
                if (idx_q == c_last_idx) begin
                    cout_d  = w_add_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign carryOutput = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_cla16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla16_seq_ctrl
// Purpose  : Directed vector table plus multi-cycle sequences for cla16_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cla16_seq_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryInput;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryOutput;

    int n_cmp;
    int n_err;

    cla16_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .carryInput  (carryInput),
`ifdef CLA16_SEQ_SUB_EN
        .sub         (sub),
`endif
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .carryOutput (carryOutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a start pulse that is accepted at the next rising edge; returns at edge+1.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic ts);
        @(negedge clk);
        a          = ta;
        b          = tb_v;
        carryInput = tc;
        sub        = ts;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    initial begin
        int cyc;
        int cyc2;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        carryInput = 1'b0;
        sub        = 1'b0;

        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h1, 1'b1});
        vecs.push_back('{64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                         64'h2222_2222_2222_2211, 1'b0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                         64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        vecs.push_back('{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0});
`ifdef CLA16_SEQ_SUB_EN
        vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1});
        vecs.push_back('{64'h0000_0001_0000_0000, 64'h1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1});
`endif
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_sum", sum, W'(0));
        chk("reset_cout", W'(carryOutput), W'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub);
            chk($sformatf("vec%0d_busy", i), W'(busy), W'(1));
            wait_done(cyc);
            chk($sformatf("vec%0d_latency", i), W'(cyc), W'(WORDS));
            chk($sformatf("vec%0d_busy_at_done", i), W'(busy), W'(0));
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].esum);
            chk($sformatf("vec%0d_cout", i), W'(carryOutput), W'(vecs[i].ecout));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), W'(done), W'(0));
        end

        // Start while busy is ignored; carryOutput holds the old value (1) mid-run.
        start_op(64'h3, 64'h4, 1'b0, 1'b0);
        @(negedge clk);
        a     = 64'h100;
        b     = 64'h100;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ignore_cout_held", W'(carryOutput), W'(1));
        chk("ignore_busy", W'(busy), W'(1));
        wait_done(cyc);
        chk("ignore_sum", sum, 64'h7);
        chk("ignore_cout", W'(carryOutput), W'(0));

        // Back-to-back: start raised during the DONE cycle.
        a     = 64'hA;
        b     = 64'h14;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", W'(busy), W'(1));
        wait_done(cyc2);
        chk("b2b_gap", W'(cyc2 + 1), W'(WORDS + 1));
        chk("b2b_sum", sum, 64'h1E);

        // Asynchronous reset mid-run at idx=2.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        wait_done(cyc);
        chk("pre_rst_cout", W'(carryOutput), W'(1));
        start_op(64'h5, 64'h6, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_sum", sum, W'(0));
        chk("rst_cout", W'(carryOutput), W'(0));
        @(negedge clk);
        rst = 1'b0;
        start_op(64'h3, 64'h4, 1'b0, 1'b0);
        wait_done(cyc);
        chk("post_rst_latency", W'(cyc), W'(WORDS));
        chk("post_rst_sum", sum, 64'h7);
        chk("post_rst_cout", W'(carryOutput), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
